// File: rtl/dsram_responder.sv
// Data-SRAM responder: word RAM plus LED/switch/timer registers, 1-cycle registered read data.
// Build option: define DSRAM_TIMER_EN to implement TIMER_COUNT, TIMER_CMP and timer_irq.
module dsram_responder #(
   parameter int          RAM_AW    = 10,
   parameter logic [15:0] PERIPH_HI = 16'hBFAF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   input  logic [7:0]  switch,
   output logic        timer_irq
);
   localparam int          RAM_WORDS  = 1 << RAM_AW;
   localparam logic [15:0] OFF_LED    = 16'hF000;
   localparam logic [15:0] OFF_SWITCH = 16'hF020;
   localparam logic [15:0] OFF_COUNT  = 16'hE000;
   localparam logic [15:0] OFF_CMP    = 16'hE004;

   logic [31:0]       ram [RAM_WORDS];
   logic              is_periph;
   logic [RAM_AW-1:0] ram_idx;
   logic [15:0]       off;
   logic              ram_wr;
   logic              full_wr;
   logic [15:0]       led_q;
   logic [7:0]        sw_p1;
   logic [7:0]        sw_p2;
   logic [31:0]       periph_rd;
   logic [31:0]       rd_mux;
   logic [31:0]       rdata_p1;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++)
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      return res;
   endfunction

   assign is_periph = (data_sram_addr[31:16] == PERIPH_HI);
   assign ram_idx   = data_sram_addr[RAM_AW+1:2];
   assign off       = data_sram_addr[15:0];
   assign ram_wr    = data_sram_en && !is_periph && (data_sram_wen != 4'h0);
   assign full_wr   = data_sram_en && is_periph && (data_sram_wen == 4'hF);

   // Request stage -> RAM array (contents survive reset; a write under reset is dropped)
   always_ff @(posedge clk) begin
      if (ram_wr && !rst)
         ram[ram_idx] <= byte_merge(ram[ram_idx], data_sram_wdata, data_sram_wen);
   end

`ifdef DSRAM_TIMER_EN
   logic [31:0] count_q;
   logic [31:0] cmp_q;
   logic        irq_q;
   logic        count_wr;
   logic        cmp_wr;

   assign count_wr = full_wr && (off == OFF_COUNT);
   assign cmp_wr   = full_wr && (off == OFF_CMP);

   // Request stage -> timer state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         cmp_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         count_q <= count_wr ? data_sram_wdata : count_q + 32'd1;
         if (cmp_wr)
            cmp_q <= data_sram_wdata;
         if (cmp_wr)
            irq_q <= 1'b0;
         else if ((count_q == cmp_q) && (cmp_q != 32'd0))
            irq_q <= 1'b1;
      end
   end

   assign timer_irq = irq_q;
`else
   assign timer_irq = 1'b0;
`endif

   always_comb begin
      periph_rd = '0;
      case (off)
         OFF_LED:    periph_rd = {16'h0000, led_q};
         OFF_SWITCH: periph_rd = {24'h000000, sw_p2};
`ifdef DSRAM_TIMER_EN
         OFF_COUNT:  periph_rd = count_q;
         OFF_CMP:    periph_rd = cmp_q;
`endif
         default:    periph_rd = '0;
      endcase
   end

   // Read-first: the mux sees pre-edge contents, so a write cycle returns old data
   assign rd_mux = is_periph ? periph_rd : ram[ram_idx];

   // Request stage -> registered read data, LED register and switch synchronizer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_p1 <= '0;
         led_q    <= '0;
         sw_p1    <= '0;
         sw_p2    <= '0;
      end else begin
         sw_p1 <= switch;
         sw_p2 <= sw_p1;
         if (data_sram_en)
            rdata_p1 <= rd_mux;
         if (full_wr && (off == OFF_LED))
            led_q <= data_sram_wdata[15:0];
      end
   end

   assign data_sram_rdata = rdata_p1;
   assign led             = led_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Directed bench for dsram_responder: vector table for RAM/LED accesses plus
// hand sequences for switch latency, timer (or its absence) and async reset.
module tb_dsram_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [15:0] led;
   logic [7:0]  switch;
   logic        timer_irq;

   int checks   = 0;
   int failures = 0;

   dsram_responder dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .led             (led),
      .switch          (switch),
      .timer_irq       (timer_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic [15:0] exp_led;
   } vec_t;

   vec_t tbl [17];

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      data_sram_en    = en;
      data_sram_wen   = wen;
      data_sram_addr  = addr;
      data_sram_wdata = wdata;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344, 1'b0, 32'h0,          16'h0000};
      tbl[1]  = '{1'b1, 4'h2, 32'h0000_0010, 32'h0000_AA00, 1'b1, 32'h1122_3344, 16'h0000};
      tbl[2]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,          1'b1, 32'h1122_AA44, 16'h0000};
      tbl[3]  = '{1'b1, 4'hF, 32'h0000_1010, 32'hDEAD_BEEF, 1'b1, 32'h1122_AA44, 16'h0000};
      tbl[4]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,          1'b1, 32'hDEAD_BEEF, 16'h0000};
      tbl[5]  = '{1'b1, 4'hF, 32'h0000_0014, 32'h0BAD_F00D, 1'b0, 32'h0,          16'h0000};
      tbl[6]  = '{1'b1, 4'h0, 32'h0000_0014, 32'h0,          1'b1, 32'h0BAD_F00D, 16'h0000};
      tbl[7]  = '{1'b1, 4'h8, 32'h0000_0014, 32'hAA00_0000, 1'b1, 32'h0BAD_F00D, 16'h0000};
      tbl[8]  = '{1'b1, 4'h0, 32'h0000_0014, 32'h0,          1'b1, 32'hAAAD_F00D, 16'h0000};
      tbl[9]  = '{1'b1, 4'hF, 32'hBFAF_F000, 32'hFFFF_A5A5, 1'b1, 32'h0,          16'hA5A5};
      tbl[10] = '{1'b1, 4'h0, 32'hBFAF_F000, 32'h0,          1'b1, 32'h0000_A5A5, 16'hA5A5};
      tbl[11] = '{1'b1, 4'h1, 32'hBFAF_F000, 32'h0000_0000, 1'b1, 32'h0000_A5A5, 16'hA5A5};
      tbl[12] = '{1'b1, 4'h0, 32'hBFAF_F000, 32'h0,          1'b1, 32'h0000_A5A5, 16'hA5A5};
      tbl[13] = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,          1'b1, 32'h0000_A5A5, 16'hA5A5};
      tbl[14] = '{1'b1, 4'hF, 32'hBFAF_1234, 32'h1234_5678, 1'b1, 32'h0,          16'hA5A5};
      tbl[15] = '{1'b1, 4'h0, 32'hBFAF_1234, 32'h0,          1'b1, 32'h0,          16'hA5A5};
      tbl[16] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,          1'b1, 32'hDEAD_BEEF, 16'hA5A5};

      rst             = 1'b0;
      data_sram_en    = 1'b0;
      data_sram_wen   = 4'h0;
      data_sram_addr  = '0;
      data_sram_wdata = '0;
      switch          = 8'h00;
      #2 rst = 1'b1;
      #1;
      chk32("reset_rdata", data_sram_rdata, 32'h0);
      chk32("reset_led",   {16'h0, led},    32'h0);
      chk32("reset_irq",   {31'h0, timer_irq}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].en, tbl[i].wen, tbl[i].addr, tbl[i].wdata);
         if (tbl[i].chk_rd)
            chk32($sformatf("vec%0d_rdata", i), data_sram_rdata, tbl[i].exp_rd);
         chk32($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
      end

      // Switch becomes visible on the third read after it changes
      switch = 8'h3C;
      drive(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
      chk32("switch_edge1", data_sram_rdata, 32'h0);
      drive(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
      chk32("switch_edge2", data_sram_rdata, 32'h0);
      drive(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
      chk32("switch_edge3", data_sram_rdata, 32'h0000_003C);

`ifdef DSRAM_TIMER_EN
      drive(1'b1, 4'hF, 32'hBFAF_E000, 32'h0);
      drive(1'b1, 4'hF, 32'hBFAF_E004, 32'h5);
      for (int k = 2; k <= 5; k++) drive(1'b0, 4'h0, 32'h0, 32'h0);
      chk32("irq_before_match", {31'h0, timer_irq}, 32'h0);
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      chk32("irq_at_match", {31'h0, timer_irq}, 32'h1);
      repeat (3) drive(1'b0, 4'h0, 32'h0, 32'h0);
      chk32("irq_sticky", {31'h0, timer_irq}, 32'h1);
      drive(1'b1, 4'hF, 32'hBFAF_E004, 32'h0);
      chk32("irq_cleared", {31'h0, timer_irq}, 32'h0);
      repeat (5) drive(1'b0, 4'h0, 32'h0, 32'h0);
      chk32("irq_stays_low", {31'h0, timer_irq}, 32'h0);
      drive(1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
      drive(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
      chk32("count_fffffffe", data_sram_rdata, 32'hFFFF_FFFE);
      drive(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
      chk32("count_ffffffff", data_sram_rdata, 32'hFFFF_FFFF);
      drive(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
      chk32("count_wrap", data_sram_rdata, 32'h0);
`else
      drive(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
      chk32("no_timer_count", data_sram_rdata, 32'h0);
      drive(1'b1, 4'hF, 32'hBFAF_E004, 32'h5);
      repeat (8) drive(1'b0, 4'h0, 32'h0, 32'h0);
      chk32("no_timer_irq", {31'h0, timer_irq}, 32'h0);
      drive(1'b1, 4'h0, 32'hBFAF_E004, 32'h0);
      chk32("no_timer_cmp", data_sram_rdata, 32'h0);
`endif

      // Async reset mid-request; the write held across the reset edge is lost
      drive(1'b1, 4'hF, 32'h0000_0018, 32'h1111_1111);
      drive(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
      chk32("pre_reset_rdata", data_sram_rdata, 32'h0000_A5A5);
      @(negedge clk);
      data_sram_en    = 1'b1;
      data_sram_wen   = 4'hF;
      data_sram_addr  = 32'h0000_0018;
      data_sram_wdata = 32'h2222_2222;
      #2 rst = 1'b1;
      #1;
      chk32("async_rst_rdata", data_sram_rdata, 32'h0);
      chk32("async_rst_led",   {16'h0, led},    32'h0);
      chk32("async_rst_irq",   {31'h0, timer_irq}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst          = 1'b0;
      data_sram_en = 1'b0;
      drive(1'b1, 4'h0, 32'h0000_0018, 32'h0);
      chk32("write_lost_in_reset", data_sram_rdata, 32'h1111_1111);
      chk32("led_after_reset", {16'h0, led}, 32'h0);

      drive(1'b0, 4'h0, 32'h0, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
